// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Holds the FSM state encoding and the rule for where each row lands in the packed table.
package tt_pkg;

    typedef enum logic [1:0] {
        TT_IDLE,
        TT_SETTLE,
        TT_SAMPLE,
        TT_DONE
    } tt_state_e;

    // Row 0 lands in the MSB, which matches the library's hex notation (gate 0x2A reads back as 8'h2A).
    localparam bit TT_ROW0_MSB = 1'b1;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Loadable down-counter that paces the settle interval of each truth-table row.
// tc is high while the count is zero; the count stops at zero and does not wrap.
module tt_settle_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input combination of an N_IN-input gate in ascending order, samples its output
// after a settle interval, and packs the result into a hex truth table checked against a reference.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter  int N_IN   = 3,
    parameter  int SETTLE = 2,
    localparam int TT_W   = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] expected,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] table_out,
    output logic            match
);

    // idx carries one spare bit so the last-row compare cannot alias on wrap.
    localparam int IDX_W = N_IN + 1;
    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(TT_W - 1);
    localparam tt_state_e ROW_ENTRY = (SETTLE == 0) ? TT_SAMPLE : TT_SETTLE;

    tt_state_e        state;
    tt_state_e        state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] row_pos;
    logic [TT_W-1:0]  exp_q;
    logic [TT_W-1:0]  exp_next;
    logic [TT_W-1:0]  table_next;
    logic [N_IN-1:0]  dut_in_next;
    logic             busy_next;
    logic             done_next;
    logic             match_next;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_tc;

    tt_settle_counter #(
        .WIDTH(CNT_W)
    ) u_settle (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_value(CNT_LOAD),
        .dec       (cnt_dec),
        .tc        (cnt_tc)
    );

    assign idx_inc = idx + IDX_W'(1);
    assign row_pos = TT_ROW0_MSB ? (LAST_ROW - idx) : idx;

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        exp_next    = exp_q;
        table_next  = table_out;
        dut_in_next = dut_in;
        busy_next   = busy;
        done_next   = 1'b0;
        match_next  = match;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state)
            TT_IDLE: begin
                dut_in_next = '0;
                if (start) begin
                    exp_next    = expected;
                    table_next  = '0;
                    match_next  = 1'b0;
                    idx_next    = '0;
                    busy_next   = 1'b1;
                    cnt_load    = 1'b1;
                    state_next  = ROW_ENTRY;
                end
            end
            TT_SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt_tc) begin
                    state_next = TT_SAMPLE;
                end
            end
            TT_SAMPLE: begin
                table_next[row_pos[N_IN-1:0]] = dut_out;
                if (idx == LAST_ROW) begin
                    // match is registered alongside done so both appear in the same cycle.
                    match_next  = (table_next == exp_q);
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    dut_in_next = '0;
                    state_next  = TT_DONE;
                end else begin
                    idx_next    = idx_inc;
                    dut_in_next = idx_inc[N_IN-1:0];
                    cnt_load    = 1'b1;
                    state_next  = ROW_ENTRY;
                end
            end
            TT_DONE: begin
                dut_in_next = '0;
                state_next  = TT_IDLE;
            end
            default: begin
                state_next = TT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TT_IDLE;
            idx       <= '0;
            exp_q     <= '0;
            table_out <= '0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            exp_q     <= exp_next;
            table_out <= table_next;
            dut_in    <= dut_in_next;
            busy      <= busy_next;
            done      <= done_next;
            match     <= match_next;
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a default instance (SETTLE=2) and a SETTLE=0 instance,
// each driving a table-defined gate model; results come from a row-by-row packing model.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] exp0, exp1;
    logic [2:0] din0, din1;
    logic       dout0, dout1;
    logic       busy0, busy1, done0, done1, match0, match1;
    logic [7:0] tt0, tt1;

    // rowsN[r] is the gate output for input combination r.
    logic [7:0] rows0, rows1;
    logic       glitch0, phase0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign dout0 = rows0[din0] ^ (glitch0 & phase0);
    assign dout1 = rows1[din1];

    truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .expected(exp0), .dut_in(din0),
        .dut_out(dout0), .busy(busy0), .done(done0), .table_out(tt0), .match(match0)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1), .dut_in(din1),
        .dut_out(dout1), .busy(busy1), .done(done1), .table_out(tt1), .match(match1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_tests++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // Library encoding: row r is stored at bit 7-r of the hex code.
    function automatic logic [7:0] pack_rows(input logic [7:0] rows);
        logic [7:0] t = '0;
        for (int r = 0; r < 8; r++) t[7 - r] = rows[r];
        return t;
    endfunction

    function automatic logic [7:0] code_to_rows(input logic [7:0] code);
        logic [7:0] rv = '0;
        for (int r = 0; r < 8; r++) rv[r] = code[7 - r];
        return rv;
    endfunction

    // Called at a falling edge; returns at the falling edge of the IDLE cycle after done.
    task automatic sweep0(input logic [7:0] rowvec, input logic [7:0] exp_in,
                          input bit glitch, input bit hold, input int abort_at);
        logic [7:0] ref_tt;
        ref_tt  = pack_rows(rowvec);
        rows0   = rowvec;
        glitch0 = glitch;
        exp0    = exp_in;
        start0  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 25; c++) begin
            exp0   = 8'($urandom);
            start0 = hold ? 1'b1 : 1'($urandom_range(0, 1));
            phase0 = (c % 3) != 0;
            if (c <= 24) begin
                check("busy_in_sweep", 32'(busy0), 32'd1);
                check("done_early", 32'(done0), 32'd0);
                check("dut_in_row", 32'(din0), 32'((c - 1) / 3));
            end else begin
                check("done_pulse", 32'(done0), 32'd1);
                check("busy_at_done", 32'(busy0), 32'd0);
                check("dut_in_at_done", 32'(din0), 32'd0);
                check("table_out", 32'(tt0), 32'(ref_tt));
                check("match", 32'(match0), 32'(ref_tt == exp_in));
            end
            if (c == abort_at) begin
                rst    = 1'b1;
                phase0 = 1'b0;
                start0 = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check("abort_busy", 32'(busy0), 32'd0);
                check("abort_dut_in", 32'(din0), 32'd0);
                check("abort_table", 32'(tt0), 32'd0);
                check("abort_match", 32'(match0), 32'd0);
                check("abort_done", 32'(done0), 32'd0);
                for (int k = 0; k < 30; k++) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(done0), 32'd0);
                end
                return;
            end
            @(negedge clk);
        end
        phase0 = 1'b0;
        start0 = hold;
        check("idle_busy", 32'(busy0), 32'd0);
        check("idle_done", 32'(done0), 32'd0);
        check("idle_dut_in", 32'(din0), 32'd0);
        check("held_table", 32'(tt0), 32'(ref_tt));
        check("held_match", 32'(match0), 32'(ref_tt == exp_in));
    endtask

    task automatic sweep1(input logic [7:0] rowvec, input logic [7:0] exp_in);
        logic [7:0] ref_tt;
        ref_tt = pack_rows(rowvec);
        rows1  = rowvec;
        exp1   = exp_in;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                check("s0_busy", 32'(busy1), 32'd1);
                check("s0_done_early", 32'(done1), 32'd0);
                check("s0_dut_in", 32'(din1), 32'(c - 1));
            end else begin
                check("s0_done", 32'(done1), 32'd1);
                check("s0_table", 32'(tt1), 32'(ref_tt));
                check("s0_match", 32'(match1), 32'(ref_tt == exp_in));
            end
            @(negedge clk);
        end
        check("s0_idle_busy", 32'(busy1), 32'd0);
        check("s0_idle_done", 32'(done1), 32'd0);
    endtask

    initial begin
        logic [7:0] rv;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        exp0 = '0; exp1 = '0; rows0 = '0; rows1 = '0;
        glitch0 = 1'b0; phase0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dut_in", 32'(din0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_table", 32'(tt0), 32'd0);
        check("rst_match", 32'(match0), 32'd0);
        check("rst_table_s0", 32'(tt1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        sweep0(code_to_rows(8'h2A), 8'h2A, 1'b0, 1'b0, 0);
        check("gate_2a_literal", 32'(tt0), 32'h2A);
        sweep0(code_to_rows(8'h01), 8'h2A, 1'b0, 1'b0, 0);
        check("gate_01_literal", 32'(tt0), 32'h01);

        sweep1(code_to_rows(8'hFE), 8'hFE);
        check("gate_fe_literal", 32'(tt1), 32'hFE);
        rv = 8'($urandom);
        sweep1(rv, 8'($urandom));

        sweep0(code_to_rows(8'hC3), 8'hC3, 1'b0, 1'b0, 10);
        sweep0(code_to_rows(8'h5A), 8'h5A, 1'b0, 1'b0, 0);

        // Continuous start: next sweep begins directly after the single IDLE cycle.
        sweep0(code_to_rows(8'h96), 8'h96, 1'b0, 1'b1, 0);
        sweep0(code_to_rows(8'h3C), 8'h00, 1'b0, 1'b1, 0);
        sweep0(code_to_rows(8'h81), 8'h81, 1'b0, 1'b0, 0);

        rv = 8'($urandom);
        sweep0(rv, pack_rows(rv), 1'b1, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            rv = 8'($urandom);
            sweep0(rv, (i % 2 == 0) ? pack_rows(rv) : 8'($urandom), 1'(i % 3 == 0), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
